demux_1_2_32: RTL and testbench
===============================

DEMUX_1_2_32 -- requirements
Module: demux_1_2_32

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port in_data  input  WIDTH  word offered by the producer.
REQ-005 Port in_sel  input  1  destination select: 1 routes to output A, 0 routes to output B.
REQ-006 Port in_valid  input  1  producer offers in_data/in_sel this cycle.
REQ-007 Port in_ready  output  1  block accepts the offered word this cycle.
REQ-008 Port a_data  output  WIDTH  word held for destination A.
REQ-009 Port a_valid  output  1  a_data holds an undelivered word.
REQ-010 Port a_ready  input  1  destination A consumes a_data this cycle.
REQ-011 Port b_data, b_valid, b_ready: same widths and meanings as REQ-008..010, for destination B.
REQ-012 Port a_count  output  8  number of words delivered on A since reset, modulo 256.
REQ-013 Port b_count  output  8  number of words delivered on B since reset, modulo 256.

Function
REQ-014 The block SHALL hold one single-entry register per destination, each in state EMPTY (valid=0) or FULL (valid=1).
REQ-015 An input transfer SHALL occur in a cycle where in_valid=1 and in_ready=1.
REQ-016 An output transfer on A SHALL occur in a cycle where a_valid=1 and a_ready=1; likewise for B.
REQ-017 in_ready SHALL equal (selected register EMPTY) or (selected register FULL and its ready=1), with the selected register chosen by in_sel; in_ready SHALL NOT depend on in_valid.
REQ-018 On an input transfer, in_data SHALL be captured into the selected register on the same edge, and the matching valid SHALL read 1 in the following cycle (latency 1 cycle).
REQ-019 The non-selected register SHALL be unaffected by an input transfer.
REQ-020 Transition EMPTY->FULL: input transfer to that register.
REQ-021 Transition FULL->EMPTY: output transfer with no simultaneous input transfer to that register.
REQ-022 FULL with simultaneous output transfer and input transfer to the same register: the register SHALL stay FULL and load the new word (no bubble, no loss).
REQ-023 FULL with ready=0: data and valid SHALL hold unchanged; in_ready=0 while in_sel selects it.
REQ-024 A full, stalled destination SHALL NOT block input transfers to the other destination.
REQ-025 a_data/b_data SHALL be stable while the corresponding valid=1 and no output transfer has occurred.
REQ-026 a_count SHALL increment by 1 on each output transfer on A, wrapping 255->0; b_count likewise for B.
REQ-027 Words SHALL be delivered on each destination in acceptance order; no word SHALL be duplicated or dropped.
REQ-028 Output ready asserted while the register is EMPTY SHALL have no effect.

Reset
REQ-029 While reset=1 at a rising edge: a_valid=0, b_valid=0, a_data=0, b_data=0, a_count=0, b_count=0.
REQ-030 in_ready SHALL be 0 during any cycle in which reset=1; no input transfer is accepted.
REQ-031 Reset asserted while registers are FULL SHALL discard held words without any output transfer being counted.
REQ-032 First input transfer SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-033 Reset then in_valid=1, in_sel=1, in_data=0x0000_00AA, a_ready=1 -> next cycle a_valid=1, a_data=0x0000_00AA, b_valid=0; after transfer a_count=1.
REQ-034 a_ready=0, send 0x11 to A, then offer 0x22 to A -> in_ready=0 with a_data=0x11 held; offer 0x33 with in_sel=0 -> accepted, b_data=0x33 next cycle.
REQ-035 A FULL with 0x44, a_ready=1 and simultaneous input 0x55 to A -> next cycle a_valid=1, a_data=0x55; a_count incremented by 1.
REQ-036 Stream 256 words to B with b_ready=1 back-to-back -> one accept per cycle, words in order, b_count wraps to 0.
REQ-037 Both registers FULL (0x66 on A, 0x77 on B), assert reset one cycle -> all valids 0, counts 0, data 0; 0x66/0x77 never transferred.
REQ-038 Random in_valid/in_sel/a_ready/b_ready for 10000 cycles against a scoreboard -> per-destination order preserved, no loss or duplication, counts match scoreboard modulo 256.

Source files
------------

// File: rtl/demux_1_2_32.sv
// demux_1_2_32: routes each accepted word into one of two single-entry output registers.
// Each destination is an independent skid-free slot that can refill in the cycle it drains.
module demux_1_2_32_slot #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic [7:0]       count
);
   logic drain;
   assign drain = valid & ready;
   always_ff @(posedge clk) begin
      if (reset) begin
         data  <= '0;
         valid <= 1'b0;
         count <= 8'd0;
      end else begin
         if (load) data <= din;
         valid <= load | (valid & ~ready);
         if (drain) count <= count + 8'd1;
      end
   end
endmodule

module demux_1_2_32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] b_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [7:0]       a_count,
   output logic [7:0]       b_count
);
   logic take;
   // A slot can accept when empty or when it is being drained this same cycle.
   assign in_ready = ~reset & (in_sel ? (~a_valid | a_ready) : (~b_valid | b_ready));
   assign take     = in_valid & in_ready;
   demux_1_2_32_slot #(.WIDTH(WIDTH)) u_a (
      .clk(clk), .reset(reset), .load(take & in_sel), .din(in_data),
      .ready(a_ready), .data(a_data), .valid(a_valid), .count(a_count)
   );
   demux_1_2_32_slot #(.WIDTH(WIDTH)) u_b (
      .clk(clk), .reset(reset), .load(take & ~in_sel), .din(in_data),
      .ready(b_ready), .data(b_data), .valid(b_valid), .count(b_count)
   );
endmodule

// File: tb/tb_demux_1_2_32.sv
// tb_demux_1_2_32: directed vectors plus a random phase, checked by a queue scoreboard.
module tb_demux_1_2_32;
   localparam int WIDTH = 32;
   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] in_data;
   logic             in_sel, in_valid, in_ready;
   logic [WIDTH-1:0] a_data, b_data;
   logic             a_valid, b_valid, a_ready, b_ready;
   logic [7:0]       a_count, b_count;
   int total = 0;
   int bad = 0;
   logic mon_en = 1'b0;
   logic [WIDTH-1:0] qa[$];
   logic [WIDTH-1:0] qb[$];
   logic [7:0] ca = 8'd0;
   logic [7:0] cb = 8'd0;

   demux_1_2_32 #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data),
      .a_valid(a_valid), .a_ready(a_ready), .b_data(b_data),
      .b_valid(b_valid), .b_ready(b_ready), .a_count(a_count), .b_count(b_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic ar, input logic br);
      in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
      @(posedge clk);
      #1;
   endtask

   // Monitor: samples on the falling edge what the next rising edge will do.
   always @(negedge clk) begin
      if (mon_en) begin
         if (reset) begin
            chk("in_ready_in_reset", {31'd0, in_ready}, 0);
            qa.delete(); qb.delete();
            ca = 8'd0; cb = 8'd0;
         end else begin
            logic exp_rdy;
            logic [WIDTH-1:0] w;
            exp_rdy = in_sel ? (qa.size() == 0 || a_ready) : (qb.size() == 0 || b_ready);
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            chk("a_valid", {31'd0, a_valid}, {31'd0, qa.size() != 0});
            chk("b_valid", {31'd0, b_valid}, {31'd0, qb.size() != 0});
            chk("a_count", {24'd0, a_count}, {24'd0, ca});
            chk("b_count", {24'd0, b_count}, {24'd0, cb});
            if (a_valid && a_ready) begin
               if (qa.size() == 0) begin
                  total++; bad++;
                  $display("FAIL a_extra: got word %0h expected none", a_data);
               end else begin
                  w = qa.pop_front();
                  chk("a_data", a_data, w);
                  ca = ca + 8'd1;
               end
            end
            if (b_valid && b_ready) begin
               if (qb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL b_extra: got word %0h expected none", b_data);
               end else begin
                  w = qb.pop_front();
                  chk("b_data", b_data, w);
                  cb = cb + 8'd1;
               end
            end
            if (in_valid && exp_rdy) begin
               if (in_sel) qa.push_back(in_data);
               else qb.push_back(in_data);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      in_valid = 0; in_sel = 0; in_data = 0; a_ready = 0; b_ready = 0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      @(posedge clk); #1;
      chk("rst_a_valid", {31'd0, a_valid}, 0);
      chk("rst_b_valid", {31'd0, b_valid}, 0);
      chk("rst_a_data", a_data, 0);
      chk("rst_b_data", b_data, 0);
      chk("rst_a_count", {24'd0, a_count}, 0);
      chk("rst_b_count", {24'd0, b_count}, 0);
      reset = 1'b0;
      // First word accepted right after reset release
      drive(1, 1, 32'hAA, 1, 0);
      chk("t1_a_valid", {31'd0, a_valid}, 1);
      chk("t1_a_data", a_data, 32'hAA);
      chk("t1_b_valid", {31'd0, b_valid}, 0);
      drive(0, 0, 0, 1, 0);
      chk("t1_a_count", {24'd0, a_count}, 1);
      chk("t1_a_empty", {31'd0, a_valid}, 0);
      // Stalled A must not block B
      drive(1, 1, 32'h11, 0, 0);
      in_valid = 1; in_sel = 1; in_data = 32'h22;
      #1;
      chk("t2_stall_in_ready", {31'd0, in_ready}, 0);
      chk("t2_hold_a_data", a_data, 32'h11);
      @(posedge clk); #1;
      chk("t2_hold_a_data2", a_data, 32'h11);
      drive(1, 0, 32'h33, 0, 0);
      chk("t2_b_data", b_data, 32'h33);
      chk("t2_b_valid", {31'd0, b_valid}, 1);
      chk("t2_a_data3", a_data, 32'h11);
      drive(0, 0, 0, 1, 1);
      chk("t2_a_count", {24'd0, a_count}, 2);
      chk("t2_b_count", {24'd0, b_count}, 1);
      // Simultaneous drain and refill of A
      drive(1, 1, 32'h44, 0, 0);
      drive(1, 1, 32'h55, 1, 0);
      chk("t3_a_valid", {31'd0, a_valid}, 1);
      chk("t3_a_data", a_data, 32'h55);
      chk("t3_a_count", {24'd0, a_count}, 3);
      drive(0, 0, 0, 1, 0);
      chk("t3_a_count2", {24'd0, a_count}, 4);
      // Back-to-back stream of 256 words to B, counting from a fresh reset
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         in_valid = 1; in_sel = 0; in_data = 32'h1000 + i; a_ready = 0; b_ready = 1;
         #1;
         chk("t4_in_ready", {31'd0, in_ready}, 1);
         @(posedge clk); #1;
      end
      chk("t4_last_b_data", b_data, 32'h10FF);
      chk("t4_b_count_255", {24'd0, b_count}, 255);
      drive(0, 0, 0, 0, 1);
      chk("t4_b_count_wrap", {24'd0, b_count}, 0);
      // Reset discards full registers
      drive(1, 1, 32'h66, 0, 0);
      drive(1, 0, 32'h77, 0, 0);
      chk("t5_a_full", a_data, 32'h66);
      chk("t5_b_full", b_data, 32'h77);
      reset = 1'b1;
      drive(0, 0, 0, 1, 1);
      reset = 1'b0;
      chk("t5_a_valid", {31'd0, a_valid}, 0);
      chk("t5_b_valid", {31'd0, b_valid}, 0);
      chk("t5_a_data", a_data, 0);
      chk("t5_b_data", b_data, 0);
      chk("t5_a_count", {24'd0, a_count}, 0);
      chk("t5_b_count", {24'd0, b_count}, 0);
      drive(0, 0, 0, 1, 1);
      chk("t5_a_count2", {24'd0, a_count}, 0);
      chk("t5_b_count2", {24'd0, b_count}, 0);
      // Random traffic, order and counts checked by the monitor
      for (int i = 0; i < 10000; i++)
         drive(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      drive(0, 0, 0, 1, 1);
      drive(0, 0, 0, 1, 1);
      chk("end_a_drained", {31'd0, a_valid}, 0);
      chk("end_b_drained", {31'd0, b_valid}, 0);
      @(negedge clk);
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
